// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32I datapath and a variable-latency data memory.
// Drives a req/gnt/rvalid handshake, aligns store lanes, extends load data and flags errors.
module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_store,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [2:0]              f3_q;
    logic                    we_q;
    logic                    mis_q;
    logic                    berr_q;

    logic                    st_in;
    logic                    unsup_in;
    logic                    misal_in;
    logic                    bad_in;
    logic                    start;
    logic                    cap;
    logic                    to_err;
    logic                    tmo;

    logic [DATA_WIDTH-1:0]   lane_wdata;
    logic [3:0]              lane_be;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   ld_ext;

    // Classify the incoming access: load wins over store, reject bad size/alignment
    always_comb begin
        st_in    = i_store & ~i_load;
        unsup_in = 1'b0;
        misal_in = 1'b0;
        if (i_load) begin
            unsup_in = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) ||
                       (i_funct3 == 3'd7);
        end else begin
            unsup_in = i_funct3[2] || (i_funct3[1:0] == 2'd3);
        end
        case (i_funct3[1:0])
            2'd1:    misal_in = i_addr[0];
            2'd2:    misal_in = |i_addr[1:0];
            default: misal_in = 1'b0;
        endcase
        bad_in = unsup_in | misal_in;
    end

    // Place store data on the byte lanes selected by the captured address
    always_comb begin
        lane_wdata = '0;
        lane_be    = 4'b1111;
        if (we_q) begin
            unique case (1'b1)
                (f3_q[1:0] == 2'd0): begin
                    lane_wdata = {4{data_q[7:0]}};
                    lane_be    = 4'b0001 << addr_q[1:0];
                end
                (f3_q[1:0] == 2'd1): begin
                    lane_wdata = {2{data_q[15:0]}};
                    lane_be    = 4'b0011 << {addr_q[1], 1'b0};
                end
                default: begin
                    lane_wdata = data_q;
                    lane_be    = 4'b1111;
                end
            endcase
        end
    end

    // Select the addressed byte/half of the response and extend it
    always_comb begin
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'd0:    ld_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    ld_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    ld_ext = {24'd0, shifted[7:0]};
            3'd5:    ld_ext = {16'd0, shifted[15:0]};
            default: ld_ext = rdata_q;
        endcase
    end

    assign tmo = (cnt_q >= TMO_LAST);

    // Next-state and output decode; reset forces every output low
    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        cap          = 1'b0;
        to_err       = 1'b0;
        o_stall      = 1'b0;
        o_done       = 1'b0;
        o_load_data  = '0;
        o_misaligned = 1'b0;
        o_bus_err    = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        case (state_q)
            IDLE: begin
                if (i_load | i_store) begin
                    o_stall = 1'b1;
                    start   = 1'b1;
                    state_d = bad_in ? DONE : REQ;
                end
            end
            REQ: begin
                o_stall     = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_we    = we_q;
                o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                o_mem_wdata = lane_wdata;
                o_mem_be    = lane_be;
                if (i_mem_gnt) begin
                    state_d = RSP;
                end else if (tmo) begin
                    to_err  = 1'b1;
                    state_d = DONE;
                end
            end
            RSP: begin
                o_stall = 1'b1;
                if (i_mem_rvalid) begin
                    cap     = 1'b1;
                    state_d = DONE;
                end else if (tmo) begin
                    to_err  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done       = 1'b1;
                o_misaligned = mis_q;
                o_bus_err    = berr_q;
                if (!we_q && !mis_q && !berr_q) begin
                    o_load_data = ld_ext;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_rst) begin
            o_stall      = 1'b0;
            o_done       = 1'b0;
            o_load_data  = '0;
            o_misaligned = 1'b0;
            o_bus_err    = 1'b0;
            o_mem_req    = 1'b0;
            o_mem_we     = 1'b0;
            o_mem_addr   = '0;
            o_mem_wdata  = '0;
            o_mem_be     = '0;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout counter: cleared when an access starts, counts through REQ/RSP
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == RSP)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Capture the access fields and its error status when it is accepted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q <= '0;
            data_q <= '0;
            f3_q   <= '0;
            we_q   <= 1'b0;
            mis_q  <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q <= i_addr;
                data_q <= i_store_data;
                f3_q   <= i_funct3;
                we_q   <= st_in;
                mis_q  <= bad_in;
                berr_q <= 1'b0;
            end
            if (to_err) begin
                berr_q <= 1'b1;
            end
        end
    end

    // Hold the read response until the datapath retires the load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (cap) begin
            rdata_q <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-level memory reference model.
// A small memory responder answers the handshake with programmable gnt/rvalid delays.
module tb_lsu_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        stall;
    logic        done;
    logic [31:0] ldata;
    logic        mis;
    logic        berr;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem  [0:255];
    logic [7:0]  refb [0:1023];

    always #5 clk = ~clk;

    lsu_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_load(ld),
        .i_store(st),
        .i_funct3(f3),
        .i_addr(addr),
        .i_store_data(sdata),
        .o_stall(stall),
        .o_done(done),
        .o_load_data(ldata),
        .o_misaligned(mis),
        .o_bus_err(berr),
        .o_mem_req(req),
        .o_mem_we(we),
        .o_mem_addr(maddr),
        .o_mem_wdata(wdata),
        .o_mem_be(be),
        .i_mem_gnt(gnt),
        .i_mem_rvalid(rvalid),
        .i_mem_rdata(rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input bit is_ld, input logic [2:0] fn,
                                 input logic [31:0] a);
        int sz;
        if (is_ld) begin
            if (!(fn == 0 || fn == 1 || fn == 2 || fn == 4 || fn == 5))
                return 1'b0;
        end else if (fn > 2) begin
            return 1'b0;
        end
        sz = int'(fn) % 4;
        if (sz == 1 && (a % 2) != 0) return 1'b0;
        if (sz == 2 && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] fn,
                                             input logic [31:0] a);
        int i;
        logic [31:0] b;
        logic [31:0] h;
        i = int'(a[9:0]);
        b = 32'(refb[i]);
        h = 32'(refb[i]) + 32'(refb[(i + 1) % 1024]) * 256;
        case (fn)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return {refb[i + 3], refb[i + 2], refb[i + 1], refb[i]};
        endcase
    endfunction

    task automatic set_word(input int a, input logic [31:0] v);
        mem[a / 4] = v;
        for (int k = 0; k < 4; k++) refb[a + k] = v[8*k +: 8];
    endtask

    task automatic access(input bit l, input bit s, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] d,
                          input int g, input int r);
        bit          eld;
        bit          ok;
        bit          to;
        bit          granted;
        bit          got_done;
        int          stalls;
        int          reqs;
        int          rsp_n;
        int          off;
        int          exp_st;
        int          exp_rq;
        logic [31:0] exp_ld;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        eld    = l;
        ok     = legal(eld, fn, a);
        to     = ok && (g >= T);
        exp_ld = (eld && ok && !to) ? ref_load(fn, a) : 32'd0;
        off    = int'(a[1:0]);
        exp_be = 4'b1111;
        exp_wd = d;
        if (!eld && fn == 3'd0) begin
            exp_be = 4'(1 << off);
            exp_wd = {4{d[7:0]}};
        end else if (!eld && fn == 3'd1) begin
            exp_be = (off >= 2) ? 4'b1100 : 4'b0011;
            exp_wd = {2{d[15:0]}};
        end
        granted  = 0;
        got_done = 0;
        stalls   = 0;
        reqs     = 0;
        rsp_n    = 0;
        @(negedge clk);
        ld     = l;
        st     = s;
        f3     = fn;
        addr   = a;
        sdata  = d;
        gnt    = 0;
        rvalid = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) begin
                got_done = 1;
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_mis", 32'(mis), 32'(!ok));
                chk("done_berr", 32'(berr), 32'(to));
                chk("done_ldata", ldata, exp_ld);
                chk("done_req", 32'(req), 32'd0);
                break;
            end
            chk("ldata_idle", ldata, 32'd0);
            if (stall) stalls++;
            gnt    = 0;
            rvalid = 0;
            rdata  = $urandom;
            if (granted) begin
                chk("req_drop", 32'(req), 32'd0);
                if (rsp_n == r) begin
                    rvalid = 1;
                    rdata  = mem[a[9:2]];
                end
                rsp_n++;
            end else if (req) begin
                if (reqs == 0) begin
                    chk("maddr", maddr, {a[31:2], 2'b00});
                    chk("we", 32'(we), 32'(!eld));
                    chk("be", 32'(be), 32'(exp_be));
                    if (!eld) chk("wdata", wdata, exp_wd);
                end
                if (reqs == g) begin
                    gnt     = 1;
                    granted = 1;
                    if (we) begin
                        for (int k = 0; k < 4; k++)
                            if (be[k])
                                mem[maddr[9:2]][8*k +: 8] = wdata[8*k +: 8];
                    end
                end
                reqs++;
            end
            @(negedge clk);
        end
        ld     = 0;
        st     = 0;
        gnt    = 0;
        rvalid = 0;
        chk("done_seen", 32'(got_done), 32'd1);
        exp_st = !ok ? 1 : (to ? 1 + T : 3 + g + r);
        exp_rq = !ok ? 0 : (to ? T : g + 1);
        chk("stall_cnt", 32'(stalls), 32'(exp_st));
        chk("req_cnt", 32'(reqs), 32'(exp_rq));
        if (!eld && ok && !to) begin
            for (int k = 0; k < (1 << int'(fn)); k++)
                refb[int'(a[9:0]) + k] = d[8*k +: 8];
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  fn;
        int          g;
        rst    = 1;
        ld     = 0;
        st     = 0;
        f3     = 0;
        addr   = 0;
        sdata  = 0;
        gnt    = 0;
        rvalid = 0;
        rdata  = 0;
        for (int i = 0; i < 256; i++) set_word(i * 4, $urandom);
        ld = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_be", 32'(be), 32'd0);
        @(negedge clk);
        ld  = 0;
        rst = 0;

        set_word(32'h100, 32'hDEADBEEF);
        access(1, 0, 3'd2, 32'h100, 0, 0, 0);
        set_word(32'h100, 32'h80112233);
        chk("lb_model", ref_load(3'd0, 32'h103), 32'hFFFFFF80);
        access(1, 0, 3'd0, 32'h103, 0, 0, 0);
        access(1, 0, 3'd4, 32'h103, 0, 1, 2);
        access(1, 0, 3'd5, 32'h102, 0, 2, 1);
        access(0, 1, 3'd1, 32'h206, 32'h0000ABCD, 0, 0);
        access(1, 0, 3'd2, 32'h204, 0, 0, 0);
        access(1, 0, 3'd2, 32'h101, 0, 0, 0);
        access(0, 1, 3'd4, 32'h200, 32'h1234, 0, 0);
        access(1, 1, 3'd0, 32'h301, 32'h55, 0, 1);
        access(1, 0, 3'd2, 32'h100, 0, 99, 0);

        @(negedge clk);
        rvalid = 1;
        rdata  = 32'hCAFEF00D;
        #1;
        chk("late_rv_done", 32'(done), 32'd0);
        chk("late_rv_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rvalid = 0;
        #1;
        chk("late_rv_done2", 32'(done), 32'd0);

        @(negedge clk);
        ld   = 1;
        f3   = 3'd2;
        addr = 32'h100;
        #1;
        chk("rr_stall0", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("rr_req", 32'(req), 32'd1);
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        #1;
        chk("rr_rsp_stall", 32'(stall), 32'd1);
        rst = 1;
        #1;
        chk("rr_rst_stall", 32'(stall), 32'd0);
        chk("rr_rst_req", 32'(req), 32'd0);
        chk("rr_rst_addr", maddr, 32'd0);
        ld = 0;
        @(negedge clk);
        rst    = 0;
        rvalid = 1;
        rdata  = 32'h0BADBAD0;
        #1;
        chk("rr_no_done", 32'(done), 32'd0);
        chk("rr_idle", 32'(stall), 32'd0);
        @(negedge clk);
        rvalid = 0;
        #1;
        chk("rr_no_done2", 32'(done), 32'd0);
        access(1, 0, 3'd2, 32'h100, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            a  = 32'($urandom_range(0, 1019));
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFFFFFC | 32'($urandom_range(0, 1)) * 2;
            fn = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) fn = 3'($urandom_range(0, 2)) | (fn & 3'b100);
            g  = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0, 1:    access(1, 0, fn, a, $urandom, g, int'($urandom_range(0, 3)));
                2, 3:    access(0, 1, fn, a, $urandom, g, int'($urandom_range(0, 3)));
                default: access(1, 1, fn, a, $urandom, g, int'($urandom_range(0, 3)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
